// File: rtl/axi_enhanced_pkg.sv
// rtl/axi_enhanced_pkg.sv - shared channel and arbiter state encodings
package axi_enhanced_pkg;

  localparam int NUM_CH = 4;

  typedef enum logic [1:0] {
    CH_CFG = 2'b00,
    CH_CC  = 2'b01,
    CH_RW  = 2'b10,
    CH_RR  = 2'b11
  } chan_e;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } arb_state_e;

endpackage

// File: rtl/axi_enhanced_tx_rr_pick.sv
// rtl/axi_enhanced_tx_rr_pick.sv - combinational round-robin picker over four ports
module axi_enhanced_tx_rr_pick
  import axi_enhanced_pkg::*;
(
  input  logic [3:0] req,
  input  logic [1:0] last,
  output logic [1:0] gnt,
  output logic       gnt_vld
);

  // Scan from the port after the last winner; the last winner itself is tried last.
  always_comb begin
    gnt     = last;
    gnt_vld = 1'b0;
    for (int i = 1; i <= NUM_CH; i++) begin
      if (!gnt_vld && req[2'(last + 2'(i))]) begin
        gnt     = 2'(last + 2'(i));
        gnt_vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axi_enhanced_tx_arbiter.sv
// rtl/axi_enhanced_tx_arbiter.sv - packet-locked TX arbiter for CFG, CC, RW and RR streams
module axi_enhanced_tx_arbiter
  import axi_enhanced_pkg::*;
#(
  parameter int    TCQ            = 1,
  parameter string CFG_PRIORITY   = "TRUE",
  parameter int    MAX_CFG_CONSEC = 4
) (
  input  logic       com_iclk,
  input  logic       com_sysrst,
  input  logic       trn_lnk_up,
  input  logic       s_axis_cfg_tvalid,
  input  logic       s_axis_cc_tvalid,
  input  logic       s_axis_rw_tvalid,
  input  logic       s_axis_rr_tvalid,
  input  logic       s_axis_cfg_tlast,
  input  logic       s_axis_cc_tlast,
  input  logic       s_axis_rw_tlast,
  input  logic       s_axis_rr_tlast,
  input  logic       s_axis_cfg_tready,
  input  logic       s_axis_cc_tready,
  input  logic       s_axis_rw_tready,
  input  logic       s_axis_rr_tready,
  input  logic       cc_thrtl,
  input  logic       rw_thrtl,
  input  logic       rr_thrtl,
  output logic [1:0] channel_sel,
  output logic       arb_busy
);

  localparam bit         CFG_PRIO_EN = (CFG_PRIORITY == "TRUE");
  localparam logic [3:0] CFG_CNT_MAX = 4'(MAX_CFG_CONSEC);

  if (TCQ < 0 || MAX_CFG_CONSEC < 1 || MAX_CFG_CONSEC > 15) begin : g_bad_param
    $error("axi_enhanced_tx_arbiter: TCQ must be >= 0 and MAX_CFG_CONSEC within 1..15");
  end

  arb_state_e state_q, state_d;
  logic [1:0] chan_q, chan_d;
  logic       busy_q, busy_d;
  logic [3:0] cnt_q, cnt_d;

  logic [3:0] tvalid, tready, tlast, req;
  logic [1:0] pick_gnt, winner;
  logic       pick_gnt_vld, cfg_wins, others_req, sel_done;

  // Vectors are indexed by the channel encoding so the lock can mux by chan_q.
  assign tvalid = {s_axis_rr_tvalid, s_axis_rw_tvalid, s_axis_cc_tvalid, s_axis_cfg_tvalid};
  assign tready = {s_axis_rr_tready, s_axis_rw_tready, s_axis_cc_tready, s_axis_cfg_tready};
  assign tlast  = {s_axis_rr_tlast,  s_axis_rw_tlast,  s_axis_cc_tlast,  s_axis_cfg_tlast};

  // CFG is never throttled; the other ports drop out of arbitration while throttled.
  assign req = {tvalid[3] & ~rr_thrtl, tvalid[2] & ~rw_thrtl, tvalid[1] & ~cc_thrtl, tvalid[0]};

  assign others_req = |req[3:1];
  assign cfg_wins   = CFG_PRIO_EN && req[0] && (cnt_q < CFG_CNT_MAX);
  assign winner     = cfg_wins ? CH_CFG : pick_gnt;
  assign sel_done   = tvalid[chan_q] & tready[chan_q] & tlast[chan_q];

  axi_enhanced_tx_rr_pick u_rr_pick (
    .req     (req),
    .last    (chan_q),
    .gnt     (pick_gnt),
    .gnt_vld (pick_gnt_vld)
  );

  // Next-state: grant from IDLE, hold the lock until tlast or link loss.
  always_comb begin
    state_d = state_q;
    chan_d  = chan_q;
    busy_d  = busy_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        busy_d = 1'b0;
        if (trn_lnk_up && pick_gnt_vld) begin
          state_d = ST_LOCKED;
          busy_d  = 1'b1;
          chan_d  = winner;
          if (winner == CH_CFG && others_req) begin
            cnt_d = (cnt_q < CFG_CNT_MAX) ? cnt_q + 4'd1 : cnt_q;
          end else begin
            cnt_d = 4'd0;
          end
        end
      end
      ST_LOCKED: begin
        if (!trn_lnk_up || sel_done) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State, selected channel, busy flag and CFG run counter.
  always_ff @(posedge com_iclk) begin
    if (com_sysrst) begin
      state_q <= ST_IDLE;
      chan_q  <= CH_RR;
      busy_q  <= 1'b0;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      chan_q  <= chan_d;
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
    end
  end

  assign channel_sel = chan_q;
  assign arb_busy    = busy_q;

endmodule
